// File: rtl/light_pkg.sv
// Shared types and constants for the lamp-bus safety monitor.
// Lamp field layout per direction d: lights[3d+2:3d] = {red, yellow, green}.
package light_pkg;

  localparam int NUM_DIR = 4;
  localparam int DIR_N   = 0;
  localparam int DIR_E   = 1;
  localparam int DIR_S   = 2;
  localparam int DIR_W   = 3;

  localparam int BIT_GREEN  = 0;
  localparam int BIT_YELLOW = 1;
  localparam int BIT_RED    = 2;

  localparam logic [2:0] CODE_GREEN  = 3'(1 << BIT_GREEN);
  localparam logic [2:0] CODE_YELLOW = 3'(1 << BIT_YELLOW);
  localparam logic [2:0] CODE_RED    = 3'(1 << BIT_RED);

  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ENCODING     = 3'd1;
  localparam logic [2:0] FC_TRANSITION   = 3'd2;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd3;
  localparam logic [2:0] FC_CONFLICT     = 3'd4;

  typedef enum logic [1:0] {RED, YELLOW, GREEN, ILLEGAL} lamp_state_t;
  typedef enum logic {MONITOR, FAULT} mon_state_t;

  function automatic lamp_state_t decode_lamp(input logic [2:0] field);
    case (field)
      CODE_RED:    return RED;
      CODE_YELLOW: return YELLOW;
      CODE_GREEN:  return GREEN;
      default:     return ILLEGAL;
    endcase
  endfunction

  function automatic logic is_go(input lamp_state_t st);
    return (st == GREEN) || (st == YELLOW);
  endfunction

  // Lowest set index wins when several directions flag in one cycle.
  function automatic logic [1:0] lowest_dir(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/light_dir_check.sv
// One direction's lamp decode, previous-state tracking and the per-direction
// encoding / transition / short-yellow checks.
module light_dir_check
  import light_pkg::*;
#(
  parameter int MIN_YELLOW = 4,
  parameter int GLITCH_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  i_lamp,
  input  logic        i_check_en,
  input  logic        i_reload,
  output lamp_state_t o_state,
  output logic        o_err_enc,
  output logic        o_err_trans,
  output logic        o_err_short
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int GW = $clog2(GLITCH_CYC + 1);

  lamp_state_t     w_cur;
  lamp_state_t     r_prev;
  logic [YW-1:0]   r_yel_cnt;
  logic [GW-1:0]   r_glitch_cnt;
  logic            w_bad_move;

  assign w_cur   = decode_lamp(i_lamp);
  assign o_state = w_cur;

  always_comb begin
    w_bad_move = 1'b0;
    if ((r_prev == GREEN  && w_cur == RED)    ||
        (r_prev == RED    && w_cur == YELLOW) ||
        (r_prev == YELLOW && w_cur == GREEN))
      w_bad_move = 1'b1;
  end

  // The current illegal sample is the one that brings the count to GLITCH_CYC.
  assign o_err_enc   = i_check_en && (w_cur == ILLEGAL) &&
                       (r_glitch_cnt >= GW'(GLITCH_CYC - 1));
  assign o_err_trans = i_check_en && w_bad_move;
  assign o_err_short = i_check_en && (r_prev == YELLOW) && (w_cur == RED) &&
                       (r_yel_cnt < YW'(MIN_YELLOW));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev       <= RED;
      r_yel_cnt    <= '0;
      r_glitch_cnt <= '0;
    end else if (i_reload) begin
      r_prev       <= (w_cur == ILLEGAL) ? RED : w_cur;
      r_yel_cnt    <= '0;
      r_glitch_cnt <= '0;
    end else if (i_check_en) begin
      if (w_cur != ILLEGAL) r_prev <= w_cur;
      if (w_cur == YELLOW) begin
        if (r_yel_cnt < YW'(MIN_YELLOW)) r_yel_cnt <= r_yel_cnt + YW'(1);
      end else begin
        r_yel_cnt <= '0;
      end
      if (w_cur == ILLEGAL) begin
        if (r_glitch_cnt < GW'(GLITCH_CYC)) r_glitch_cnt <= r_glitch_cnt + GW'(1);
      end else begin
        r_glitch_cnt <= '0;
      end
    end else begin
      r_yel_cnt    <= '0;
      r_glitch_cnt <= '0;
    end
  end

endmodule

// File: rtl/light_monitor.sv
// Lamp-bus safety monitor: passes lights through until the first fault, then
// flashes all-red until clear_fault. Optional LIGHT_MON_FAULT_COUNT_EN adds fault_count.
//   state   | meaning
//   MONITOR | checks active, safe_lights follows lights one cycle late
//   FAULT   | fault latched, safe_lights flashes all-red / dark
module light_monitor
  import light_pkg::*;
#(
  parameter int MIN_YELLOW = 4,
  parameter int GLITCH_CYC = 2,
  parameter int FLASH_HALF = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] lights,
  input  logic        clear_fault,
  output logic [11:0] safe_lights,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_dir
`ifdef LIGHT_MON_FAULT_COUNT_EN
  ,
  output logic [7:0]  fault_count
`endif
);

  localparam int            FW         = $clog2(2 * FLASH_HALF);
  localparam logic [FW-1:0] FLASH_LAST = FW'(2 * FLASH_HALF - 1);
  localparam logic [FW-1:0] FLASH_H    = FW'(FLASH_HALF);

  mon_state_t    r_state;
  logic [FW-1:0] r_flash;
  logic [FW-1:0] w_flash_nxt;
  lamp_state_t   w_state [NUM_DIR];
  logic [3:0]    w_enc, w_trans, w_short;
  logic          w_check, w_reload, w_conflict, w_hit;
  logic [2:0]    w_code;
  logic [1:0]    w_dir;

  assign w_check  = (r_state == MONITOR);
  assign w_reload = (r_state == FAULT) && clear_fault;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    light_dir_check #(
      .MIN_YELLOW (MIN_YELLOW),
      .GLITCH_CYC (GLITCH_CYC)
    ) u_dir_check (
      .clk         (clk),
      .reset       (reset),
      .i_lamp      (lights[3*d +: 3]),
      .i_check_en  (w_check),
      .i_reload    (w_reload),
      .o_state     (w_state[d]),
      .o_err_enc   (w_enc[d]),
      .o_err_trans (w_trans[d]),
      .o_err_short (w_short[d])
    );
  end

  assign w_conflict = w_check &&
                      (is_go(w_state[DIR_N]) || is_go(w_state[DIR_S])) &&
                      (is_go(w_state[DIR_E]) || is_go(w_state[DIR_W]));

  always_comb begin
    w_hit  = 1'b1;
    w_code = FC_NONE;
    w_dir  = 2'd0;
    if (w_conflict) begin
      w_code = FC_CONFLICT;
    end else if (|w_enc) begin
      w_code = FC_ENCODING;
      w_dir  = lowest_dir(w_enc);
    end else if (|w_trans) begin
      w_code = FC_TRANSITION;
      w_dir  = lowest_dir(w_trans);
    end else if (|w_short) begin
      w_code = FC_SHORT_YELLOW;
      w_dir  = lowest_dir(w_short);
    end else begin
      w_hit  = 1'b0;
    end
  end

  assign w_flash_nxt = (r_flash == FLASH_LAST) ? '0 : r_flash + FW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= MONITOR;
      r_flash     <= '0;
      safe_lights <= ALL_RED;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      fault_dir   <= 2'd0;
    end else begin
      case (r_state)
        MONITOR: begin
          if (w_hit) begin
            r_state     <= FAULT;
            r_flash     <= '0;
            safe_lights <= ALL_RED;
            fault       <= 1'b1;
            fault_code  <= w_code;
            fault_dir   <= w_dir;
          end else begin
            safe_lights <= lights;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            r_state     <= MONITOR;
            r_flash     <= '0;
            safe_lights <= lights;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            fault_dir   <= 2'd0;
          end else begin
            r_flash     <= w_flash_nxt;
            safe_lights <= (w_flash_nxt < FLASH_H) ? ALL_RED : 12'h000;
          end
        end
        default: r_state <= MONITOR;
      endcase
    end
  end

`ifdef LIGHT_MON_FAULT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_count <= 8'd0;
    end else if (w_check && w_hit && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'd1;
    end
  end
`endif

endmodule
